// File: rtl/encoder4to2_pipe.sv
// Registered one-hot to binary encoder with valid/ready handshakes on both sides.
// Define ENC_PRIORITY_EN to priority-encode multi-hot words (highest index wins) instead of flagging them.
module encoder4to2_pipe #(
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 d0,
  input  logic                 d1,
  input  logic                 d2,
  input  logic                 d3,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 a,
  output logic                 b,
  output logic                 zero,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  logic [3:0] d_word;
  logic       enc_a;
  logic       enc_b;
  logic       enc_zero;
  logic       enc_err;
  logic       in_fire;
  logic       out_fire;

  logic                 valid_q, valid_d;
  logic                 a_q, a_d;
  logic                 b_q, b_d;
  logic                 zero_q, zero_d;
  logic                 err_q, err_d;
  logic [ERR_CNT_W-1:0] cnt_q, cnt_d;

  assign d_word   = {d3, d2, d1, d0};
  assign in_ready = !valid_q || out_ready;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = valid_q && out_ready;

  always_comb begin
    enc_a    = 1'b0;
    enc_b    = 1'b0;
    enc_zero = 1'b0;
    enc_err  = 1'b0;
    case (d_word)
      4'b0001: ;
      4'b0010: enc_b = 1'b1;
      4'b0100: enc_a = 1'b1;
      4'b1000: begin
        enc_a = 1'b1;
        enc_b = 1'b1;
      end
      4'b0000: begin
        enc_zero = 1'b1;
        enc_err  = 1'b1;
      end
      default: begin
`ifdef ENC_PRIORITY_EN
        // Highest set index wins.
        if (d3) begin
          enc_a = 1'b1;
          enc_b = 1'b1;
        end else if (d2) begin
          enc_a = 1'b1;
        end else begin
          enc_b = 1'b1;
        end
`else
        enc_err = 1'b1;
`endif
      end
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    a_d     = a_q;
    b_d     = b_q;
    zero_d  = zero_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    if (in_fire) begin
      valid_d = 1'b1;
      a_d     = enc_a;
      b_d     = enc_b;
      zero_d  = enc_zero;
      err_d   = enc_err;
      if (enc_err && (cnt_q != {ERR_CNT_W{1'b1}})) begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (out_fire) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid = valid_q;
  assign a         = a_q;
  assign b         = b_q;
  assign zero      = zero_q;
  assign err       = err_q;
  assign err_cnt   = cnt_q;

endmodule

// File: tb/tb_encoder4to2_pipe.sv
// Directed self-checking bench for encoder4to2_pipe (counter width 3, saturates at 7).
module tb_encoder4to2_pipe;

  localparam int unsigned CntW = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      d;
  logic            out_valid;
  logic            out_ready;
  logic            a;
  logic            b;
  logic            zero;
  logic            err;
  logic [CntW-1:0] err_cnt;

  int checks   = 0;
  int failures = 0;
  int exp_cnt  = 0;

  encoder4to2_pipe #(.ERR_CNT_W(CntW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .d0        (d[0]),
    .d1        (d[1]),
    .d2        (d[2]),
    .d3        (d[3]),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .a         (a),
    .b         (b),
    .zero      (zero),
    .err       (err),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      $error("check %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks the full registered output bundle.
  task automatic chk_out(input string tag, input logic v, input logic [1:0] ab,
                         input logic z, input logic e, input int cnt);
    chk({tag, "_valid"}, out_valid, v);
    chk({tag, "_ab"}, {a, b}, ab);
    chk({tag, "_zero"}, zero, z);
    chk({tag, "_err"}, err, e);
    chk({tag, "_cnt"}, err_cnt, cnt);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    d         = 4'b0000;
    #2;
    chk_out("reset", 1'b0, 2'b00, 1'b0, 1'b0, 0);
    chk("reset_in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;

    // Streaming one-hot words at full throughput.
    in_valid  = 1'b1;
    out_ready = 1'b1;
    d = 4'b0001;
    tick();
    chk_out("s0", 1'b1, 2'b00, 1'b0, 1'b0, 0);
    d = 4'b0010;
    tick();
    chk_out("s1", 1'b1, 2'b01, 1'b0, 1'b0, 0);
    d = 4'b0100;
    tick();
    chk_out("s2", 1'b1, 2'b10, 1'b0, 1'b0, 0);
    d = 4'b1000;
    tick();
    chk_out("s3", 1'b1, 2'b11, 1'b0, 1'b0, 0);
    in_valid = 1'b0;
    tick();
    chk("drain_valid", out_valid, 1'b0);
    chk("drain_ab_hold", {a, b}, 2'b11);

    // Backpressure: 0100 held while 1000 waits.
    in_valid  = 1'b1;
    out_ready = 1'b0;
    d = 4'b0100;
    tick();
    chk_out("bp_load", 1'b1, 2'b10, 1'b0, 1'b0, 0);
    d = 4'b1000;
    #1;
    chk("bp_in_ready", in_ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("bp_hold", 1'b1, 2'b10, 1'b0, 1'b0, 0);
      chk("bp_hold_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", in_ready, 1'b1);
    tick();
    chk_out("bp_next", 1'b1, 2'b11, 1'b0, 1'b0, 0);
    in_valid = 1'b0;
    tick();
    chk("bp_drain", out_valid, 1'b0);

    // Zero and multi-hot words.
    in_valid = 1'b1;
    d = 4'b0000;
    tick();
    exp_cnt = 1;
    chk_out("zero_word", 1'b1, 2'b00, 1'b1, 1'b1, exp_cnt);
    d = 4'b0101;
    tick();
`ifdef ENC_PRIORITY_EN
    chk_out("multi_hot", 1'b1, 2'b10, 1'b0, 1'b0, exp_cnt);
`else
    exp_cnt = 2;
    chk_out("multi_hot", 1'b1, 2'b00, 1'b0, 1'b1, exp_cnt);
`endif

    // Saturation at 2^CntW-1 = 7.
    d = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      tick();
      exp_cnt = (exp_cnt < 7) ? exp_cnt + 1 : 7;
      chk_out("sat", 1'b1, 2'b00, 1'b1, 1'b1, exp_cnt);
    end
    chk("sat_final", err_cnt, 3'd7);

    // Rebuild err_cnt=5 with a valid 11 word pending, then reset between edges.
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_cnt_clear", err_cnt, 3'd0);
    @(negedge clk);
    rst = 1'b0;
    d = 4'b0000;
    for (int i = 0; i < 5; i++) tick();
    d = 4'b1000;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk_out("pre_rst", 1'b1, 2'b11, 1'b0, 1'b0, 5);
    #3;
    rst = 1'b1;
    #1;
    chk_out("async_rst", 1'b0, 2'b00, 1'b0, 1'b0, 0);
    chk("async_rst_in_ready", in_ready, 1'b1);
    tick();
    chk("rst_held_valid", out_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    d = 4'b0010;
    #1;
    chk("post_rst_pre_edge", out_valid, 1'b0);
    tick();
    chk_out("post_rst", 1'b1, 2'b01, 1'b0, 1'b0, 0);
    in_valid = 1'b0;
    tick();
    chk("post_rst_drain", out_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
